// File: rtl/uart_nbytes_tx_pkg.sv
// rtl/uart_nbytes_tx_pkg.sv - shared state encodings and line constants for uart_nbytes_tx
// Purpose: FSM state type and UART line idle level used by the frame sender and byte sender.
package uart_nbytes_tx_pkg;

  typedef enum logic [2:0] {
    ST_IDLE = 3'd0,
    ST_TRIG = 3'd1,
    ST_WAIT = 3'd2,
    ST_GAP  = 3'd3,
    ST_FIN  = 3'd4
  } state_e;

  localparam logic UART_IDLE_LEVEL = 1'b1;

endpackage

// File: rtl/uart_nbytes_tx_byte_tx.sv
// rtl/uart_nbytes_tx_byte_tx.sv - single-byte 8N1 UART serialiser (uart_byte_tx)
// Purpose: sends one byte per pulse, LSB first, one start and one stop bit.
// Ports: clk, rst (async, active-high), speed (clk cycles per bit), tx_data, pulse (accepted
//        when not busy), tx (serial line), tx_busy (high from the pulse edge to the end of stop bit).
module uart_byte_tx
  import uart_nbytes_tx_pkg::*;
(
  input  logic        clk,
  input  logic        rst,
  input  logic [19:0] speed,
  input  logic [7:0]  tx_data,
  input  logic        pulse,
  output logic        tx,
  output logic        tx_busy
);

  logic        busy_q, busy_d;
  logic        tx_q, tx_d;
  logic [9:0]  shift_q, shift_d;
  logic [3:0]  bit_q, bit_d;
  logic [19:0] baud_q, baud_d;
  logic        baud_tick;

  // Bit period ends after 'speed' cycles; a divisor of 0 behaves like 1.
  assign baud_tick = ({1'b0, baud_q} + 21'd1) >= {1'b0, speed};

  always_comb begin
    busy_d  = busy_q;
    tx_d    = tx_q;
    shift_d = shift_q;
    bit_d   = bit_q;
    baud_d  = baud_q;
    if (!busy_q) begin
      if (pulse) begin
        busy_d  = 1'b1;
        shift_d = {1'b1, tx_data, 1'b0};
        tx_d    = 1'b0;
        bit_d   = 4'd0;
        baud_d  = 20'd0;
      end
    end else if (baud_tick) begin
      baud_d = 20'd0;
      // Bit 9 is the stop bit: busy drops only once it has been fully driven.
      if (bit_q == 4'd9) begin
        busy_d = 1'b0;
        tx_d   = UART_IDLE_LEVEL;
      end else begin
        bit_d   = bit_q + 4'd1;
        shift_d = {1'b1, shift_q[9:1]};
        tx_d    = shift_q[1];
      end
    end else begin
      baud_d = baud_q + 20'd1;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      busy_q  <= 1'b0;
      tx_q    <= UART_IDLE_LEVEL;
      shift_q <= '1;
      bit_q   <= 4'd0;
      baud_q  <= 20'd0;
    end else begin
      busy_q  <= busy_d;
      tx_q    <= tx_d;
      shift_q <= shift_d;
      bit_q   <= bit_d;
      baud_q  <= baud_d;
    end
  end

  assign tx      = tx_q;
  assign tx_busy = busy_q;

endmodule

// File: rtl/uart_nbytes_tx.sv
// rtl/uart_nbytes_tx.sv - multi-byte UART frame transmitter
// Purpose: accepts 1..MAX_BYTES bytes on start/ready and sends them back-to-back through one
//          uart_byte_tx, in selectable byte order, with an optional idle gap between bytes.
// Ports: clk, reset (async, active-low), speed, bytes2send, bytes_num, start, abort (in);
//        ready, tx, tx_busy, done (1-cycle end-of-frame pulse), bytes_sent (out).
module uart_nbytes_tx
  import uart_nbytes_tx_pkg::*;
#(
  parameter  int MAX_BYTES  = 8,
  parameter  bit MSB_FIRST  = 1'b1,
  parameter  int GAP_CYCLES = 0,
  localparam int CNT_W      = $clog2(MAX_BYTES + 1)
) (
  input  logic                   clk,
  input  logic                   reset,
  input  logic [19:0]            speed,
  input  logic [8*MAX_BYTES-1:0] bytes2send,
  input  logic [CNT_W-1:0]       bytes_num,
  input  logic                   start,
  input  logic                   abort,
  output logic                   ready,
  output logic                   tx,
  output logic                   tx_busy,
  output logic                   done,
  output logic [CNT_W-1:0]       bytes_sent
);

  localparam int PTR_W = (MAX_BYTES > 1) ? $clog2(MAX_BYTES) : 1;
  localparam int GAP_W = (GAP_CYCLES > 1) ? $clog2(GAP_CYCLES) : 1;

  state_e                 state_q, state_d;
  logic [8*MAX_BYTES-1:0] shadow_q, shadow_d;
  logic [PTR_W-1:0]       ptr_q, ptr_d;
  logic [CNT_W-1:0]       remaining_q, remaining_d;
  logic [CNT_W-1:0]       bytes_sent_q, bytes_sent_d;
  logic [GAP_W-1:0]       gap_q, gap_d;
  logic                   tx_busy_q, tx_busy_d;
  logic                   ready_q, ready_d;
  logic                   abort_q, abort_d;
  logic                   send_byte_q, send_byte_d;
  logic [7:0]             byte2send_q, byte2send_d;
  logic                   busy_d1_q, busy_d2_q;

  logic                   byte_busy;
  logic                   busy_fall;
  logic                   abort_eff;
  logic [CNT_W-1:0]       n_clamp;

  assign n_clamp   = (bytes_num > CNT_W'(MAX_BYTES)) ? CNT_W'(MAX_BYTES) : bytes_num;
  // History starts at 00 after every byte, so a stale 10 can never be seen before busy rises.
  assign busy_fall = busy_d2_q & ~busy_d1_q;
  // An abort arriving in the deciding cycle is honoured as if already latched.
  assign abort_eff = abort_q | abort;

  always_comb begin
    state_d      = state_q;
    shadow_d     = shadow_q;
    ptr_d        = ptr_q;
    remaining_d  = remaining_q;
    bytes_sent_d = bytes_sent_q;
    gap_d        = gap_q;
    tx_busy_d    = tx_busy_q;
    ready_d      = ready_q;
    abort_d      = abort_q | abort;
    send_byte_d  = 1'b0;
    byte2send_d  = byte2send_q;
    done         = 1'b0;
    case (state_q)
      ST_IDLE: begin
        abort_d = 1'b0;
        if (start && (bytes_num != '0)) begin
          shadow_d     = bytes2send;
          remaining_d  = n_clamp;
          ptr_d        = MSB_FIRST ? PTR_W'(n_clamp - CNT_W'(1)) : '0;
          bytes_sent_d = '0;
          tx_busy_d    = 1'b1;
          ready_d      = 1'b0;
          state_d      = ST_TRIG;
        end
      end
      ST_TRIG: begin
        byte2send_d = shadow_q[8*int'(ptr_q) +: 8];
        send_byte_d = 1'b1;
        // Step only while another byte follows, so ptr stays inside 0..n-1.
        if (remaining_q > CNT_W'(1)) begin
          ptr_d = MSB_FIRST ? ptr_q - PTR_W'(1) : ptr_q + PTR_W'(1);
        end
        state_d = ST_WAIT;
      end
      ST_WAIT: begin
        if (busy_fall) begin
          bytes_sent_d = bytes_sent_q + CNT_W'(1);
          if (remaining_q != '0) begin
            remaining_d = remaining_q - CNT_W'(1);
          end
          if ((remaining_q <= CNT_W'(1)) || abort_eff) begin
            state_d = ST_FIN;
          end else if (GAP_CYCLES > 0) begin
            gap_d   = GAP_W'(GAP_CYCLES - 1);
            state_d = ST_GAP;
          end else begin
            state_d = ST_TRIG;
          end
        end
      end
      ST_GAP: begin
        if (gap_q == '0) begin
          state_d = abort_eff ? ST_FIN : ST_TRIG;
        end else begin
          gap_d = gap_q - GAP_W'(1);
        end
      end
      ST_FIN: begin
        done      = 1'b1;
        tx_busy_d = 1'b0;
        ready_d   = 1'b1;
        state_d   = ST_IDLE;
      end
      default: begin
        state_d = ST_IDLE;
      end
    endcase
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q      <= ST_IDLE;
      shadow_q     <= '0;
      ptr_q        <= '0;
      remaining_q  <= '0;
      bytes_sent_q <= '0;
      gap_q        <= '0;
      tx_busy_q    <= 1'b0;
      ready_q      <= 1'b1;
      abort_q      <= 1'b0;
      send_byte_q  <= 1'b0;
      byte2send_q  <= 8'd0;
      busy_d1_q    <= 1'b0;
      busy_d2_q    <= 1'b0;
    end else begin
      state_q      <= state_d;
      shadow_q     <= shadow_d;
      ptr_q        <= ptr_d;
      remaining_q  <= remaining_d;
      bytes_sent_q <= bytes_sent_d;
      gap_q        <= gap_d;
      tx_busy_q    <= tx_busy_d;
      ready_q      <= ready_d;
      abort_q      <= abort_d;
      send_byte_q  <= send_byte_d;
      byte2send_q  <= byte2send_d;
      busy_d1_q    <= byte_busy;
      busy_d2_q    <= busy_d1_q;
    end
  end

  uart_byte_tx u_byte_tx (
    .clk     (clk),
    .rst     (~reset),
    .speed   (speed),
    .tx_data (byte2send_q),
    .pulse   (send_byte_q),
    .tx      (tx),
    .tx_busy (byte_busy)
  );

  assign ready      = ready_q;
  assign tx_busy    = tx_busy_q;
  assign bytes_sent = bytes_sent_q;

endmodule

// File: tb/tb_uart_nbytes_tx.sv
// tb/tb_uart_nbytes_tx.sv - self-checking bench for uart_nbytes_tx
module tb_uart_nbytes_tx;

  logic        clk = 1'b0;
  logic        reset;
  logic [19:0] speed;
  logic [63:0] bytes2send;
  logic [3:0]  bytes_num;
  logic        start;
  logic        abort;

  logic       ready0, tx0, busy0, done0;
  logic [3:0] sent0;
  logic       ready1, tx1, busy1, done1;
  logic [3:0] sent1;

  always #5 clk = ~clk;

  // u0: MSB first, no gap.  u1: LSB first, 5-cycle gap.  Both see identical stimulus.
  uart_nbytes_tx #(.MAX_BYTES(8), .MSB_FIRST(1'b1), .GAP_CYCLES(0)) u0 (
    .clk(clk), .reset(reset), .speed(speed), .bytes2send(bytes2send), .bytes_num(bytes_num),
    .start(start), .abort(abort), .ready(ready0), .tx(tx0), .tx_busy(busy0), .done(done0),
    .bytes_sent(sent0)
  );

  uart_nbytes_tx #(.MAX_BYTES(8), .MSB_FIRST(1'b0), .GAP_CYCLES(5)) u1 (
    .clk(clk), .reset(reset), .speed(speed), .bytes2send(bytes2send), .bytes_num(bytes_num),
    .start(start), .abort(abort), .ready(ready1), .tx(tx1), .tx_busy(busy1), .done(done1),
    .bytes_sent(sent1)
  );

  typedef struct {
    logic [63:0] data;
    logic [3:0]  num;
    logic [3:0]  exp_n;
    logic [63:0] exp0;   // received byte j at [8j+:8], MSB-first instance
    logic [63:0] exp1;   // same, LSB-first instance
  } vec_t;

  int tests = 0;
  int fails = 0;
  int cyc   = 0;
  int dcnt0 = 0;
  int dcnt1 = 0;

  logic [7:0] rx_b [2][16];
  int         rx_t [2][16];
  int         rx_n [2];

  always @(posedge clk) begin
    cyc = cyc + 1;
    if (done0) dcnt0 = dcnt0 + 1;
    if (done1) dcnt1 = dcnt1 + 1;
  end

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
    end
  endtask

  // 8N1 decoder at 16 clk/bit, sampling mid-bit on falling clock edges.
  task automatic mon(input int k);
    logic [7:0] b;
    int         st;
    forever begin
      @(negedge clk);
      if (reset && (((k == 0) ? tx0 : tx1) == 1'b0)) begin
        st = cyc;
        repeat (8) @(negedge clk);
        for (int i = 0; i < 8; i++) begin
          repeat (16) @(negedge clk);
          b[i] = (k == 0) ? tx0 : tx1;
        end
        repeat (16) @(negedge clk);
        if (rx_n[k] < 16) begin
          rx_b[k][rx_n[k]] = b;
          rx_t[k][rx_n[k]] = st;
          rx_n[k]          = rx_n[k] + 1;
        end
      end
    end
  endtask

  function automatic logic [63:0] rx_word(input int k);
    logic [63:0] w;
    w = '0;
    for (int j = 0; j < 8; j++) begin
      if (j < rx_n[k]) w[8*j +: 8] = rx_b[k][j];
    end
    return w;
  endfunction

  task automatic clear_obs();
    rx_n[0] = 0;
    rx_n[1] = 0;
    dcnt0   = 0;
    dcnt1   = 0;
  endtask

  task automatic run_frame(input string tag, input vec_t v, input int abort_after);
    int  budget;
    int  idle0, idle1;
    logic timed_out;
    @(negedge clk);
    clear_obs();
    bytes2send = v.data;
    bytes_num  = v.num;
    start      = 1'b1;
    @(posedge clk);
    #1;
    start      = 1'b0;
    bytes2send = ~v.data;
    bytes_num  = 4'd0;
    check({tag, "_accept"}, {62'd0, busy0 & busy1, ready0 | ready1}, 64'd2);
    @(posedge clk);
    @(posedge clk);
    #1;
    check({tag, "_latency"}, {62'd0, tx0, tx1}, 64'd0);
    if (abort_after > 0) begin
      budget = 0;
      while (rx_n[0] < 1 && budget < 1000) begin
        @(negedge clk);
        budget++;
      end
      repeat (abort_after) @(negedge clk);
      abort = 1'b1;
      @(negedge clk);
      abort = 1'b0;
    end
    budget    = 0;
    timed_out = 1'b0;
    while (!((dcnt0 >= 1) && (dcnt1 >= 1) && ready0 && ready1)) begin
      @(negedge clk);
      budget++;
      if (budget > 4000) begin
        timed_out = 1'b1;
        break;
      end
    end
    check({tag, "_timeout"}, {63'd0, timed_out}, 64'd0);
    repeat (20) @(negedge clk);
    check({tag, "_done_cnt"}, {dcnt0[31:0], dcnt1[31:0]}, {32'd1, 32'd1});
    check({tag, "_sent0"}, {60'd0, sent0}, {60'd0, v.exp_n});
    check({tag, "_sent1"}, {60'd0, sent1}, {60'd0, v.exp_n});
    check({tag, "_rx_n"}, {rx_n[0][31:0], rx_n[1][31:0]}, {28'd0, v.exp_n, 28'd0, v.exp_n});
    check({tag, "_data0"}, rx_word(0), v.exp0);
    check({tag, "_data1"}, rx_word(1), v.exp1);
    check({tag, "_idle"}, {60'd0, busy0, busy1, tx0, tx1}, 64'd3);
    if (v.exp_n >= 2 && rx_n[0] >= 2 && rx_n[1] >= 2) begin
      idle0 = rx_t[0][1] - rx_t[0][0] - 160;
      idle1 = rx_t[1][1] - rx_t[1][0] - 160;
      check({tag, "_spacing_le4"}, {63'd0, (idle0 >= 0) && (idle0 <= 4)}, 64'd1);
      check({tag, "_gap_delta"}, 64'(idle1 - idle0), 64'd5);
    end
  endtask

  vec_t vecs [5];
  vec_t vabort;
  int   bad;

  initial begin
    vecs[0] = '{64'h1122334455A1B2C3, 4'd3, 4'd3, 64'h0000000000C3B2A1, 64'h0000000000A1B2C3};
    vecs[1] = '{64'h0807060504030201, 4'd9, 4'd8, 64'h0102030405060708, 64'h0807060504030201};
    vecs[2] = '{64'hDEADBEEF00FF5A3C, 4'd1, 4'd1, 64'h000000000000003C, 64'h000000000000003C};
    vecs[3] = '{64'h0000000000007E81, 4'd2, 4'd2, 64'h000000000000817E, 64'h0000000000007E81};
    vecs[4] = '{64'h0F1E2D3C4B5A6978, 4'd8, 4'd8, 64'h78695A4B3C2D1E0F, 64'h0F1E2D3C4B5A6978};
    vabort  = '{64'h0000001122334455, 4'd5, 4'd2, 64'h0000000000002211, 64'h0000000000004455};

    reset      = 1'b0;
    speed      = 20'd16;
    bytes2send = '0;
    bytes_num  = '0;
    start      = 1'b0;
    abort      = 1'b0;
    rx_n[0]    = 0;
    rx_n[1]    = 0;
    fork
      mon(0);
      mon(1);
    join_none

    repeat (3) @(negedge clk);
    check("reset_flags", {56'd0, ready0, ready1, tx0, tx1, busy0, busy1, done0, done1},
          {56'd0, 8'b1111_0000});
    check("reset_sent", {56'd0, sent0, sent1}, 64'd0);
    reset = 1'b1;
    repeat (5) @(negedge clk);

    for (int i = 0; i < 5; i++) begin
      if (i == 2) begin
        // abort while idle must not affect the next frame
        abort = 1'b1;
        @(negedge clk);
        abort = 1'b0;
      end
      run_frame($sformatf("vec%0d", i), vecs[i], 0);
    end

    // bytes_num=0 with start held: nothing happens
    @(negedge clk);
    clear_obs();
    bad        = 0;
    bytes_num  = 4'd0;
    bytes2send = 64'hFFFF_FFFF_FFFF_FFFF;
    start      = 1'b1;
    repeat (200) begin
      @(negedge clk);
      if (!ready0 || !ready1 || !tx0 || !tx1 || busy0 || busy1 || done0 || done1) bad++;
    end
    start = 1'b0;
    check("zero_len_quiet", 64'(bad), 64'd0);
    check("zero_len_done", 64'(dcnt0 + dcnt1), 64'd0);

    // abort during byte 2 of 5
    run_frame("abort", vabort, 90);
    bad = 0;
    repeat (200) begin
      @(negedge clk);
      if (!tx0 || !tx1) bad++;
    end
    check("abort_tx_high", 64'(bad), 64'd0);

    // reset in the middle of byte 1
    @(negedge clk);
    bytes2send = vecs[4].data;
    bytes_num  = 4'd8;
    start      = 1'b1;
    @(negedge clk);
    start = 1'b0;
    repeat (50) @(negedge clk);
    reset = 1'b0;
    #1;
    check("midreset_flags", {56'd0, ready0, ready1, tx0, tx1, busy0, busy1, done0, done1},
          {56'd0, 8'b1111_0000});
    check("midreset_sent", {56'd0, sent0, sent1}, 64'd0);
    @(negedge clk);
    reset = 1'b1;
    repeat (300) @(negedge clk);
    run_frame("post_reset", vecs[0], 0);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
